// File: rtl/lp_calc_pkg.sv
// Shared definitions for the low-power calculator: opcodes, host FSM states, request bundle.
package lp_calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam int RESULT_LAT_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIT  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } host_state_e;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
    } calc_req_t;

endpackage

// File: rtl/lp_calc_host_wait_ctr.sv
// Loadable down-counter timing the core's result latency.
module lp_calc_host_wait_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (load)
            cnt_q <= val;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    // Asserted in the cycle whose closing edge takes the count to zero.
    assign zero = (cnt_q == W'(1));

endmodule

// File: rtl/lp_calc_host.sv
// Request/response front end for the calculator core with a one-entry result cache.
module lp_calc_host
    import lp_calc_pkg::*;
#(
    parameter int RESULT_LAT = RESULT_LAT_DEF,
    parameter int HIT_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_a,
    input  logic [3:0]           req_b,
    input  logic [1:0]           req_op,
    output logic [3:0]           calc_a,
    output logic [3:0]           calc_b,
    output logic [1:0]           calc_op,
    input  logic [7:0]           calc_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_result,
    output logic                 rsp_cached,
    output logic                 busy,
    output logic [HIT_CNT_W-1:0] hit_count
);

    localparam int CW = $clog2(RESULT_LAT + 1);

    host_state_e          state_q;
    calc_req_t            calc_q;
    logic [7:0]           cache_q;
    logic                 have_result_q;
    logic                 rsp_valid_q;
    logic [7:0]           rsp_result_q;
    logic                 rsp_cached_q;
    logic [HIT_CNT_W-1:0] hit_cnt_q;

    calc_req_t req_in;
    logic      accept;
    logic      is_hit;
    logic      ctr_load;
    logic      ctr_zero;

    assign req_in   = '{a: req_a, b: req_b, op: req_op};
    assign accept   = req_valid && (state_q == ST_IDLE);
    // All 10 operand bits take part; the pins themselves are the cache tag.
    assign is_hit   = have_result_q && (req_in == calc_q);
    assign ctr_load = accept && !is_hit;

    lp_calc_host_wait_ctr #(.W(CW)) u_wait_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (ctr_load),
        .val   (CW'(RESULT_LAT)),
        .zero  (ctr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            calc_q        <= '0;
            cache_q       <= '0;
            have_result_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_cached_q  <= 1'b0;
            hit_cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_hit) begin
                            state_q <= ST_HIT;
                        end else begin
                            calc_q  <= req_in;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_HIT: begin
                    rsp_result_q <= cache_q;
                    rsp_cached_q <= 1'b1;
                    rsp_valid_q  <= 1'b1;
                    if (hit_cnt_q != '1)
                        hit_cnt_q <= hit_cnt_q + 1'b1;
                    state_q <= ST_RESP;
                end
                ST_WAIT: begin
                    if (ctr_zero) begin
                        cache_q       <= calc_result;
                        rsp_result_q  <= calc_result;
                        rsp_cached_q  <= 1'b0;
                        have_result_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign calc_a     = calc_q.a;
    assign calc_b     = calc_q.b;
    assign calc_op    = calc_q.op;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cached = rsp_cached_q;
    assign hit_count  = hit_cnt_q;

endmodule

// File: tb/tb_lp_calc_host.sv
// Directed bench for lp_calc_host with a behavioural core model driving calc_result.
module tb_lp_calc_host;
    import lp_calc_pkg::*;

    localparam int LAT = 3;
    localparam int HW  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_a = '0, req_b = '0;
    logic [1:0]    req_op = '0;
    logic [3:0]    calc_a, calc_b;
    logic [1:0]    calc_op;
    logic [7:0]    calc_result;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [7:0]    rsp_result;
    logic          rsp_cached;
    logic          busy;
    logic [HW-1:0] hit_count;

    int n_pass = 0;
    int n_tot  = 0;
    int ev_cnt = 0;
    logic [9:0] pins_prev = '0;

    lp_calc_host #(.RESULT_LAT(LAT), .HIT_CNT_W(HW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op),
        .calc_result(calc_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cached(rsp_cached),
        .busy(busy), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    // Core model: combinational result of the current pins.
    always_comb begin
        calc_result = 8'h00;
        case (calc_op)
            OP_ADD: calc_result = {4'b0, calc_a} + {4'b0, calc_b};
            OP_SUB: calc_result = {4'b0, calc_a} - {4'b0, calc_b};
            OP_MUL: calc_result = {4'b0, calc_a} * {4'b0, calc_b};
            default: calc_result = {4'b0, calc_a & calc_b};
        endcase
    end

    // Counts core input events (any change of the registered pins).
    always @(posedge clk) begin
        #1;
        if ({calc_a, calc_b, calc_op} != pins_prev) ev_cnt++;
        pins_prev = {calc_a, calc_b, calc_op};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int n = 0;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat = 0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #2; lat++; end
        chk(tag, lat, exp_lat);
    endtask

    task automatic take(input string tag, input logic [7:0] res, input logic cached);
        chk({tag, "_res"}, {24'b0, rsp_result}, {24'b0, res});
        chk({tag, "_cached"}, {31'b0, rsp_cached}, {31'b0, cached});
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        rsp_ready = 1'b0;
        chk({tag, "_vld_drop"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int ev0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Reset state
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", {24'b0, rsp_result}, 32'd0);
        chk("rst_rsp_cached", {31'b0, rsp_cached}, 32'd0);
        chk("rst_calc", {22'b0, calc_a, calc_b, calc_op}, 32'd0);
        chk("rst_hit", {30'b0, hit_count}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        // 1: first miss 3+4
        ev0 = ev_cnt;
        issue(4'd3, 4'd4, OP_ADD);
        chk("t1_pins", {22'b0, calc_a, calc_b, calc_op}, {22'b0, 4'd3, 4'd4, 2'b00});
        chk("t1_busy", {31'b0, busy}, 32'd1);
        wait_rsp("t1_lat", LAT);
        take("t1", 8'd7, 1'b0);
        chk("t1_events", ev_cnt - ev0, 32'd1);

        // 2: identical request -> cache hit
        ev0 = ev_cnt;
        issue(4'd3, 4'd4, OP_ADD);
        wait_rsp("t2_lat", 1);
        chk("t2_hit", {30'b0, hit_count}, 32'd1);
        take("t2", 8'd7, 1'b1);
        chk("t2_events", ev_cnt - ev0, 32'd0);

        // 3: response back-pressure with a waiting request
        issue(4'd3, 4'd4, OP_ADD);
        wait_rsp("t3_lat", 1);
        req_a = 4'd5; req_b = 4'd6; req_op = OP_AND; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("t3_hold_vld", {31'b0, rsp_valid}, 32'd1);
            chk("t3_hold_res", {24'b0, rsp_result}, 32'd7);
            chk("t3_hold_rdy", {31'b0, req_ready}, 32'd0);
        end
        chk("t3_pins_held", {22'b0, calc_a, calc_b, calc_op}, {22'b0, 4'd3, 4'd4, 2'b00});
        chk("t3_hit", {30'b0, hit_count}, 32'd2);
        take("t3", 8'd7, 1'b1);
        issue(4'd5, 4'd6, OP_AND);
        wait_rsp("t3b_lat", LAT);
        take("t3b", 8'd4, 1'b0);

        // 4: back-to-back misses, wrap on subtract
        ev0 = ev_cnt;
        issue(4'd15, 4'd15, OP_MUL);
        wait_rsp("t4a_lat", LAT);
        take("t4a", 8'd225, 1'b0);
        chk("t4a_events", ev_cnt - ev0, 32'd1);
        ev0 = ev_cnt;
        issue(4'd0, 4'd1, OP_SUB);
        wait_rsp("t4b_lat", LAT);
        take("t4b", 8'hFF, 1'b0);
        chk("t4b_events", ev_cnt - ev0, 32'd1);

        // 5: reset during WAIT discards everything
        issue(4'd3, 4'd4, OP_ADD);
        @(posedge clk); #2;
        chk("t5_in_wait", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        chk("t5_vld", {31'b0, rsp_valid}, 32'd0);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_pins", {22'b0, calc_a, calc_b, calc_op}, 32'd0);
        chk("t5_hit", {30'b0, hit_count}, 32'd0);
        issue(4'd3, 4'd4, OP_ADD);
        wait_rsp("t5_lat", LAT);
        take("t5", 8'd7, 1'b0);

        // 6: hit counter saturates at 3 with a 2-bit width
        for (int i = 1; i <= 4; i++) begin
            issue(4'd3, 4'd4, OP_ADD);
            wait_rsp("t6_lat", 1);
            chk("t6_hit", {30'b0, hit_count}, (i < 3) ? i : 3);
            take("t6", 8'd7, 1'b1);
        end

        // {0,0,ADD} after reset must miss even though it matches the reset pins
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        issue(4'd0, 4'd0, OP_ADD);
        wait_rsp("t7_lat", LAT);
        take("t7", 8'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
